// File: rtl/equiv_stim_sequencer.sv
// equiv_stim_sequencer
// Drives one LFSR stimulus vector into the pre- and post-synthesis copies of a
// fuzzed design, compares their y outputs every active cycle, and reports
// pass/fail, a saturating mismatch count and where the first divergence was.
module equiv_stim_sequencer #(
    parameter int          STIM_W       = 29,
    parameter int          Y_W          = 284,
    parameter int          CYCLES       = 1024,
    parameter int          DRAIN        = 4,
    parameter int          CNT_W        = 16,
    parameter logic [31:0] SEED         = 32'h0000_0001,
    parameter logic        STOP_ON_FAIL = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic [STIM_W-1:0]      stim_out,
    output logic                   stim_valid,
    input  logic [Y_W-1:0]         y_a,
    input  logic [Y_W-1:0]         y_b,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CNT_W-1:0]       mismatch_cnt,
    output logic [CNT_W-1:0]       first_fail_cycle,
    output logic [$clog2(Y_W)-1:0] first_fail_bit
);

    // A zero seed would lock the LFSR up, so it is replaced by 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam int BW     = $clog2(Y_W);
    localparam int TOTAL  = CYCLES + DRAIN;
    localparam int TW_MIN = $clog2(TOTAL + 1);
    // The phase counter must reach CYCLES+DRAIN-1 even when the reported cycle
    // index is narrower, so it is widened as needed and cyc is its low bits.
    localparam int TW     = (CNT_W > TW_MIN) ? CNT_W : TW_MIN;
    localparam logic [TW-1:0] RUN_LAST   = TW'(CYCLES - 1);
    localparam logic [TW-1:0] DRAIN_LAST = TW'(TOTAL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]  mismatchCnt_q, mismatchCnt_d;
    logic [CNT_W-1:0]  firstCycle_q, firstCycle_d;
    logic [BW-1:0]     firstBit_q, firstBit_d;
    logic              seenFail_q, seenFail_d;
    logic              pass_q, pass_d;
    logic              busy_q, done_q;

    logic              compareEn;
    logic [Y_W-1:0]    diff;
    logic              diffNz;
    logic [BW-1:0]     lowBit;

    assign compareEn = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign diff      = y_a ^ y_b;
    assign diffNz    = |diff;

    // Find the lowest differing bit; scanning downwards lets the lowest win.
    always_comb begin
        lowBit = '0;
        for (int i = Y_W - 1; i >= 0; i--) begin
            if (diff[i]) begin
                lowBit = BW'(i);
            end
        end
    end

    // Next-state logic; abort outranks every other exit from an active phase.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (STOP_ON_FAIL && diffNz) begin
                    state_d = S_DONE;
                end else if (cnt_q == RUN_LAST) begin
                    state_d = (DRAIN == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (STOP_ON_FAIL && diffNz) begin
                    state_d = S_DONE;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values: LFSR stepping, cycle index, compare bookkeeping.
    always_comb begin
        lfsr_d        = lfsr_q;
        cnt_d         = cnt_q;
        mismatchCnt_d = mismatchCnt_q;
        firstCycle_d  = firstCycle_q;
        firstBit_d    = firstBit_q;
        seenFail_d    = seenFail_q;
        pass_d        = pass_q;

        if (state_q == S_LOAD) begin
            lfsr_d        = SEED_EFF;
            cnt_d         = '0;
            mismatchCnt_d = '0;
            firstCycle_d  = '0;
            firstBit_d    = '0;
            seenFail_d    = 1'b0;
        end

        // The last RUN value is held through DRAIN, so no step on the last RUN cycle.
        if ((state_q == S_RUN) && (cnt_q != RUN_LAST)) begin
            lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
        end

        if (compareEn) begin
            cnt_d = cnt_q + 1'b1;
            if (diffNz) begin
                if (mismatchCnt_q != {CNT_W{1'b1}}) begin
                    mismatchCnt_d = mismatchCnt_q + 1'b1;
                end
                if (!seenFail_q) begin
                    firstCycle_d = cnt_q[CNT_W-1:0];
                    firstBit_d   = lowBit;
                    seenFail_d   = 1'b1;
                end
            end
        end

        if ((state_q == S_IDLE) && start) begin
            pass_d = 1'b0;
        end else if (state_d == S_DONE) begin
            pass_d = !seenFail_d;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q        <= SEED_EFF;
            cnt_q         <= '0;
            mismatchCnt_q <= '0;
            firstCycle_q  <= '0;
            firstBit_q    <= '0;
            seenFail_q    <= 1'b0;
            pass_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            lfsr_q        <= lfsr_d;
            cnt_q         <= cnt_d;
            mismatchCnt_q <= mismatchCnt_d;
            firstCycle_q  <= firstCycle_d;
            firstBit_q    <= firstBit_d;
            seenFail_q    <= seenFail_d;
            pass_q        <= pass_d;
            busy_q        <= (state_d != S_IDLE);
            done_q        <= (state_d == S_DONE);
        end
    end

    assign stim_out         = compareEn ? lfsr_q[STIM_W-1:0] : '0;
    assign stim_valid       = compareEn;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign mismatch_cnt     = mismatchCnt_q;
    assign first_fail_cycle = firstCycle_q;
    assign first_fail_bit   = firstBit_q;

endmodule

// File: tb/tb_equiv_stim_sequencer.sv
// Testbench for equiv_stim_sequencer: scoreboard on a short-run instance plus
// two small-counter instances for saturation and stop-on-fail behaviour.
module tb_equiv_stim_sequencer;

    localparam int STIM_W = 29;
    localparam int Y_W    = 284;
    localparam int CYC_A  = 8;
    localparam int DRN_A  = 2;
    localparam int NA     = CYC_A + DRN_A;
    localparam int CYC_B  = 40;
    localparam int DRN_B  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, abort;
    logic [Y_W-1:0] ya, yb;
    logic [STIM_W-1:0] stimOut;
    logic stimValid, busy, done, pass;
    logic [15:0] mcnt, ffc;
    logic [8:0] ffb;

    logic startB, abortB;
    logic [Y_W-1:0] yaB, ybB, maskBC;
    logic [STIM_W-1:0] stimOutB, stimOutC;
    logic stimValidB, busyB, doneB, passB;
    logic stimValidC, busyC, doneC, passC;
    logic [3:0] mcntB, ffcB, mcntC, ffcC;
    logic [8:0] ffbB, ffbC;

    assign ybB = yaB ^ maskBC;

    equiv_stim_sequencer #(.STIM_W(STIM_W), .Y_W(Y_W), .CYCLES(CYC_A), .DRAIN(DRN_A),
                           .CNT_W(16), .SEED(32'h1), .STOP_ON_FAIL(1'b0)) dutA (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .stim_out(stimOut), .stim_valid(stimValid), .y_a(ya), .y_b(yb),
        .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mcnt),
        .first_fail_cycle(ffc), .first_fail_bit(ffb));

    equiv_stim_sequencer #(.STIM_W(STIM_W), .Y_W(Y_W), .CYCLES(CYC_B), .DRAIN(DRN_B),
                           .CNT_W(4), .SEED(32'h1), .STOP_ON_FAIL(1'b0)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .abort(abortB),
        .stim_out(stimOutB), .stim_valid(stimValidB), .y_a(yaB), .y_b(ybB),
        .busy(busyB), .done(doneB), .pass(passB), .mismatch_cnt(mcntB),
        .first_fail_cycle(ffcB), .first_fail_bit(ffbB));

    equiv_stim_sequencer #(.STIM_W(STIM_W), .Y_W(Y_W), .CYCLES(CYC_B), .DRAIN(DRN_B),
                           .CNT_W(4), .SEED(32'h1), .STOP_ON_FAIL(1'b1)) dutC (
        .clk(clk), .rst_n(rst_n), .start(startB), .abort(abortB),
        .stim_out(stimOutC), .stim_valid(stimValidC), .y_a(yaB), .y_b(ybB),
        .busy(busyC), .done(doneC), .pass(passC), .mismatch_cnt(mcntC),
        .first_fail_cycle(ffcC), .first_fail_bit(ffbC));

    int checks = 0;
    int passes = 0;
    int cycNow = 0;

    typedef struct packed {
        logic        passV;
        logic [15:0] cnt;
        logic [15:0] fcyc;
        logic [8:0]  fbit;
        int          doneAt;
    } res_t;

    logic [STIM_W-1:0] stimQ[$];
    res_t              resQ[$];
    logic [Y_W-1:0]    masks[NA];

    // Free-running edge counter used as the time base for latency checks.
    always @(posedge clk) cycNow <= cycNow + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] lfsrNext(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    function automatic logic [Y_W-1:0] randWide();
        logic [287:0] t;
        for (int w = 0; w < 9; w++) t[w*32 +: 32] = $urandom;
        return t[Y_W-1:0];
    endfunction

    // Reference result: count faulty cycles, locate the first one and its lowest bit.
    function automatic res_t expectRes(input int doneAt);
        res_t r;
        r.passV  = 1'b1;
        r.cnt    = '0;
        r.fcyc   = '0;
        r.fbit   = '0;
        r.doneAt = doneAt;
        for (int k = 0; k < NA; k++) begin
            if (masks[k] != '0) begin
                if (r.cnt != 16'hFFFF) r.cnt = r.cnt + 16'd1;
                if (r.passV) begin
                    r.passV = 1'b0;
                    r.fcyc  = 16'(k);
                    for (int b = Y_W - 1; b >= 0; b--) if (masks[k][b]) r.fbit = 9'(b);
                end
            end
        end
        return r;
    endfunction

    task automatic clearMasks();
        for (int k = 0; k < NA; k++) masks[k] = '0;
    endtask

    task automatic randomMasks();
        for (int k = 0; k < NA; k++) begin
            masks[k] = '0;
            if ($urandom_range(0, 3) == 0) begin
                masks[k][$urandom_range(0, Y_W - 1)] = 1'b1;
                masks[k][$urandom_range(0, Y_W - 1)] = 1'b1;
            end
        end
    endtask

    // Monitor: pops expected stimulus and results whenever the DUT presents them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stimValid) begin
                if (stimQ.size() == 0) check("unexpected_stim_valid", 64'd1, 64'd0);
                else check("stim_out", 64'(stimOut), 64'(stimQ.pop_front()));
            end
            if (done) begin
                if (resQ.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    res_t r;
                    r = resQ.pop_front();
                    check("done_cycle", 64'(cycNow), 64'(r.doneAt));
                    check("pass", 64'(pass), 64'(r.passV));
                    check("mismatch_cnt", 64'(mcnt), 64'(r.cnt));
                    check("first_fail_cycle", 64'(ffc), 64'(r.fcyc));
                    check("first_fail_bit", 64'(ffb), 64'(r.fbit));
                end
            end
        end
    end

    // One run on dutA: pushes expectations, then drives y cycle by cycle.
    task automatic applyStimulus(input int abortAt, input int startGlitchAt, input int resetAt);
        logic [31:0] l;
        int last;
        int cs;
        last = NA - 1;
        if (abortAt >= 0) last = abortAt;
        if (resetAt >= 0) last = resetAt - 1;
        l = 32'h1;
        for (int k = 0; k < NA; k++) begin
            if (k <= last) stimQ.push_back(l[STIM_W-1:0]);
            if (k < CYC_A - 1) l = lfsrNext(l);
        end
        @(posedge clk); #1;
        start = 1'b1;
        cs = cycNow;
        if (abortAt < 0 && resetAt < 0) resQ.push_back(expectRes(cs + 2 + NA));
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < NA; k++) begin
            if (abortAt >= 0 && k > abortAt) break;
            ya    = randWide();
            yb    = ya ^ masks[k];
            start = (k == startGlitchAt);
            abort = (k == abortAt);
            if (k == resetAt) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_stim_out", 64'(stimOut), 64'd0);
                check("rst_stim_valid", 64'(stimValid), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_done", 64'(done), 64'd0);
                check("rst_pass", 64'(pass), 64'd0);
                check("rst_mismatch_cnt", 64'(mcnt), 64'd0);
                check("rst_first_fail_cycle", 64'(ffc), 64'd0);
                check("rst_first_fail_bit", 64'(ffb), 64'd0);
                @(negedge clk); #1;
                rst_n = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;
        yb    = ~ya;
        if (abortAt < 0 && resetAt < 0) begin
            @(posedge clk); #1;
        end
    endtask

    // Saturation and stop-on-fail on the narrow-counter instances.
    task automatic checkOutput();
        int cs;
        int doneAtB = -1;
        int doneAtC = -1;
        maskBC = '0;
        maskBC[3] = 1'b1;
        maskBC[200] = 1'b1;
        @(posedge clk); #1;
        startB = 1'b1;
        cs = cycNow;
        @(posedge clk); #1;
        startB = 1'b0;
        for (int i = 0; i < 100 && doneAtB < 0; i++) begin
            @(negedge clk);
            yaB = randWide();
            if (doneC && doneAtC < 0) doneAtC = cycNow;
            if (doneB && doneAtB < 0) doneAtB = cycNow;
        end
        check("sat_done_cycle", 64'(doneAtB), 64'(cs + 2 + CYC_B + DRN_B));
        check("sat_mismatch_cnt", 64'(mcntB), 64'd15);
        check("sat_first_fail_bit", 64'(ffbB), 64'd3);
        check("sat_first_fail_cycle", 64'(ffcB), 64'd0);
        check("sat_pass", 64'(passB), 64'd0);
        check("stop_done_cycle", 64'(doneAtC), 64'(cs + 3));
        check("stop_mismatch_cnt", 64'(mcntC), 64'd1);
        check("stop_first_fail_bit", 64'(ffbC), 64'd3);
        check("stop_pass", 64'(passC), 64'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        startB = 1'b0;
        abortB = 1'b0;
        ya     = '0;
        yb     = '0;
        yaB    = '0;
        maskBC = '0;
        #12;
        check("reset_stim_out", 64'(stimOut), 64'd0);
        check("reset_stim_valid", 64'(stimValid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_pass", 64'(pass), 64'd0);
        check("reset_mismatch_cnt", 64'(mcnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] clean run with LFSR sequence");
        clearMasks();
        applyStimulus(-1, -1, -1);

        $display("[TB] single fault at cyc 5 bit 17");
        clearMasks();
        masks[5][17] = 1'b1;
        applyStimulus(-1, -1, -1);

        $display("[TB] randomized fault runs");
        for (int r = 0; r < 6; r++) begin
            randomMasks();
            applyStimulus(-1, -1, -1);
        end

        $display("[TB] abort at cyc 3 with ignored start");
        clearMasks();
        masks[1][100] = 1'b1;
        applyStimulus(3, 1, -1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_pass", 64'(pass), 64'd0);
        check("abort_mismatch_cnt", 64'(mcnt), 64'd1);
        check("abort_first_fail_cycle", 64'(ffc), 64'd1);
        check("abort_first_fail_bit", 64'(ffb), 64'd100);
        repeat (3) @(posedge clk);

        $display("[TB] restart after abort");
        clearMasks();
        applyStimulus(-1, -1, -1);

        $display("[TB] reset during drain");
        clearMasks();
        masks[2][5] = 1'b1;
        applyStimulus(-1, -1, CYC_A);
        #1;
        check("post_reset_busy", 64'(busy), 64'd0);
        check("post_reset_stim_valid", 64'(stimValid), 64'd0);

        $display("[TB] run after reset");
        randomMasks();
        applyStimulus(-1, -1, -1);

        $display("[TB] saturation and stop-on-fail");
        checkOutput();

        repeat (3) @(posedge clk);
        check("stim_queue_drained", 64'(stimQ.size()), 64'd0);
        check("result_queue_drained", 64'(resQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
